// File: rtl/vector_mem_ctrl.sv
// Vector load/store controller between the word-wide data memory and the
// 4 x VLEN vector register file. One command in flight at a time.
module vector_mem_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned VLEN   = 512,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [1:0]        cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              rf_load,
  output logic [1:0]        rf_load_addr,
  output logic [VLEN-1:0]   rf_load_data,
  output logic              rf_store,
  output logic [1:0]        rf_store_addr,
  input  logic [VLEN-1:0]   rf_store_data
);

  localparam int unsigned BEATS = VLEN / WORD_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_DRAIN, LD_WB, ST_RF, ST_CAP, ST_WR, DONE
  } state_t;

  state_t                          state, state_next;
  logic [CNT_W-1:0]                cnt;
  logic [1:0]                      reg_q;
  logic [ADDR_W-1:0]               base_q;
  logic [BEATS-1:0][WORD_W-1:0]    buf_q;
  logic                            rd_vld_q;
  logic [CNT_W-1:0]                rd_idx_q;
  logic                            accept;
  logic                            last_beat;
  logic [ADDR_W-1:0]               beat_addr;

  // Ready is combinational on reset so no command slips in during reset.
  assign cmd_ready    = (state == IDLE) && !reset;
  assign accept       = cmd_valid && cmd_ready;
  assign last_beat    = (cnt == CNT_W'(BEATS - 1));
  assign beat_addr    = base_q + ADDR_W'(cnt);
  assign rf_load_data = buf_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and strobe decode; strobes and bus values depend only on state.
  always_comb begin
    state_next    = state;
    busy          = (state != IDLE);
    done          = 1'b0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    rf_load       = 1'b0;
    rf_load_addr  = '0;
    rf_store      = 1'b0;
    rf_store_addr = '0;
    case (state)
      IDLE: begin
        if (accept) state_next = cmd_store ? ST_RF : LD_RD;
      end
      LD_RD: begin
        mem_re   = 1'b1;
        mem_addr = beat_addr;
        if (last_beat) state_next = LD_DRAIN;
      end
      LD_DRAIN: state_next = LD_WB;
      LD_WB: begin
        rf_load      = 1'b1;
        rf_load_addr = reg_q;
        done         = 1'b1;
        state_next   = IDLE;
      end
      ST_RF: begin
        rf_store      = 1'b1;
        rf_store_addr = reg_q;
        state_next    = ST_CAP;
      end
      ST_CAP: state_next = ST_WR;
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = buf_q[cnt];
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, beat counter and vector buffer. Read data returns one
  // cycle after the strobe, so the beat index is delayed alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      reg_q    <= '0;
      base_q   <= '0;
      buf_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      if (accept) begin
        reg_q  <= cmd_reg;
        base_q <= cmd_addr;
        cnt    <= '0;
      end else if (state == LD_RD || state == ST_WR) begin
        cnt <= cnt + CNT_W'(1);
      end
      rd_vld_q <= (state == LD_RD);
      rd_idx_q <= cnt;
      if (rd_vld_q)        buf_q[rd_idx_q] <= mem_rdata;
      if (state == ST_CAP) buf_q           <= rf_store_data;
    end
  end

endmodule
